sc_layer_engine: RTL and testbench

Stochastic-computing neural-network layer with built-in weight stream generation and run control. Binary weights are converted on-chip to bitstreams with a shared LFSR. Each neuron multiplies input and weight streams in unipolar (AND) or bipolar (XNOR) mode and combines its inputs by round-robin scaled addition. A start/busy/done handshake bounds each evaluation window, and a per-neuron popcount gives a binary activation for the next layer or for readout.

---
 rtl/sc_pkg.sv | 29 ++
 rtl/sc_sng.sv | 29 ++
 rtl/sc_layer_engine.sv | 122 ++++++++++++
 tb/tb_sc_layer_engine.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-computing layer engine.
// Galois LFSR masks are right-shift form, indexed by register width.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_UNI = 1'b0,
    MODE_BI  = 1'b1
  } mode_e;

  localparam logic [31:0] LFSR_TAPS [4:32] = '{
    32'h0000000C, 32'h00000014, 32'h00000030,
    32'h00000060, 32'h000000B8, 32'h00000110,
    32'h00000240, 32'h00000500, 32'h00000E08,
    32'h00001C80, 32'h00003802, 32'h00006000,
    32'h0000B400, 32'h00012000, 32'h00020400,
    32'h00072000, 32'h00090000, 32'h00140000,
    32'h00300000, 32'h00420000, 32'h00E10000,
    32'h01200000, 32'h02000023, 32'h04000013,
    32'h09000000, 32'h14000000, 32'h20000029,
    32'h48000000, 32'h80200003
  };

endpackage

// File: rtl/sc_sng.sv
// Shared weight-stream LFSR: maximal-length Galois register
// with synchronous reload and advance enable.
module sc_sng
  import sc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEED  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  output logic [WIDTH-1:0] lfsr
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS[WIDTH]);
  localparam logic [WIDTH-1:0] INIT = WIDTH'(SEED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= INIT;
    end else if (load) begin
      lfsr <= INIT;
    end else if (en) begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/sc_layer_engine.sv
// Stochastic-computing layer: on-chip weight streams, AND/XNOR
// products, round-robin scaled addition and windowed popcounts.
module sc_layer_engine
  import sc_pkg::*;
#(
  parameter int INPUT_SIZE   = 2,
  parameter int NEURON_COUNT = 2,
  parameter int WEIGHT_LEN   = 16,
  parameter int STREAM_LEN_W = 8,
  parameter int LFSR_SEED    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bipolar,
  input  logic [STREAM_LEN_W-1:0] stream_len,
  input  logic [NEURON_COUNT-1:0][INPUT_SIZE-1:0][WEIGHT_LEN-1:0]
               layer_weights,
  input  logic [INPUT_SIZE-1:0] layer_input,
  output logic [NEURON_COUNT-1:0] layer_output,
  output logic layer_output_valid,
  output logic [NEURON_COUNT-1:0][STREAM_LEN_W-1:0] layer_count,
  output logic busy,
  output logic done
);

  localparam int SW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [SW-1:0] SEL_MAX = SW'(INPUT_SIZE - 1);
  localparam logic [STREAM_LEN_W-1:0] ONE = STREAM_LEN_W'(1);

  state_e state_q, state_d;
  mode_e  mode_q;
  logic [STREAM_LEN_W-1:0] len_q;
  logic [SW-1:0] sel_q;
  logic [WEIGHT_LEN-1:0] lfsr;
  logic accept, run;

  logic [INPUT_SIZE-1:0][WEIGHT_LEN-1:0] rot;
  logic [NEURON_COUNT-1:0][INPUT_SIZE-1:0] p;
  logic [NEURON_COUNT-1:0] obit;

  assign accept = (state_q == IDLE) && start;
  assign run    = (state_q == RUN);
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

  sc_sng #(
    .WIDTH (WEIGHT_LEN),
    .SEED  (LFSR_SEED)
  ) u_sng (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .load (accept),
    .lfsr (lfsr)
  );

  // Each input column sees its own rotation of the shared LFSR
  for (genvar j = 0; j < INPUT_SIZE; j++) begin : g_rot
    localparam int R = j % WEIGHT_LEN;
    if (R == 0) begin : g_id
      assign rot[j] = lfsr;
    end else begin : g_rl
      assign rot[j] = {lfsr[WEIGHT_LEN-1-R:0],
                       lfsr[WEIGHT_LEN-1 -: R]};
    end
  end

  for (genvar i = 0; i < NEURON_COUNT; i++) begin : g_n
    for (genvar j = 0; j < INPUT_SIZE; j++) begin : g_in
      logic wbit;
      assign wbit = rot[j] < layer_weights[i][j];
      assign p[i][j] = (mode_q == MODE_BI)
                     ? ~(layer_input[j] ^ wbit)
                     : (layer_input[j] & wbit);
    end
    assign obit[i] = p[i][sel_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start)
              state_d = (stream_len == '0) ? DONE : RUN;
      RUN:  if (len_q == ONE) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q             <= MODE_UNI;
      len_q              <= '0;
      sel_q              <= '0;
      layer_output       <= '0;
      layer_output_valid <= 1'b0;
      layer_count        <= '0;
    end else begin
      layer_output_valid <= run;
      if (accept) begin
        mode_q      <= mode_e'(bipolar);
        len_q       <= stream_len;
        sel_q       <= '0;
        layer_count <= '0;
      end
      if (run) begin
        len_q        <= len_q - ONE;
        sel_q        <= (sel_q == SEL_MAX) ? '0 : sel_q + SW'(1);
        layer_output <= obit;
        for (int i = 0; i < NEURON_COUNT; i++)
          layer_count[i] <= layer_count[i] + STREAM_LEN_W'(obit[i]);
      end
    end
  end

endmodule

// File: tb/tb_sc_layer_engine.sv
// Directed bench for sc_layer_engine: a default 2x2 instance and
// an 8-bit single-input instance for the full-period check.
module tb_sc_layer_engine;
  import sc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start = 1'b0;
  logic bipolar = 1'b0;
  logic [7:0] stream_len = '0;
  logic [1:0][1:0][15:0] w0 = '0;
  logic [1:0] in0 = '0;
  logic [1:0] out0;
  logic vld0;
  logic [1:0][7:0] lc0;
  logic busy0, done0;

  logic start1 = 1'b0;
  logic [7:0] len1 = 8'd255;
  logic [0:0][0:0][7:0] w1 = '0;
  logic [0:0] in1 = '0;
  logic [0:0] out1;
  logic vld1;
  logic [0:0][7:0] lc1;
  logic busy1, done1;

  sc_layer_engine u0 (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .bipolar            (bipolar),
    .stream_len         (stream_len),
    .layer_weights      (w0),
    .layer_input        (in0),
    .layer_output       (out0),
    .layer_output_valid (vld0),
    .layer_count        (lc0),
    .busy               (busy0),
    .done               (done0)
  );

  sc_layer_engine #(
    .INPUT_SIZE   (1),
    .NEURON_COUNT (1),
    .WEIGHT_LEN   (8)
  ) u1 (
    .clk                (clk),
    .rst                (rst),
    .start              (start1),
    .bipolar            (1'b0),
    .stream_len         (len1),
    .layer_weights      (w1),
    .layer_input        (in1),
    .layer_output       (out1),
    .layer_output_valid (vld1),
    .layer_count        (lc1),
    .busy               (busy1),
    .done               (done1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_cyc, done_n, vcnt;
  logic [15:0] pat;
  logic [1:0][7:0] lc_done;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycle c is sampled 1 time unit after the c-th edge past start
  task automatic run0(input logic bip, input logic [7:0] n,
                      input int midc);
    done_cyc = 0;
    done_n   = 0;
    vcnt     = 0;
    pat      = '0;
    lc_done  = '0;
    @(negedge clk);
    bipolar    = bip;
    stream_len = n;
    start      = 1'b1;
    for (int c = 1; c <= n + 6; c++) begin
      @(posedge clk);
      #1;
      if (c == midc) begin
        start      = 1'b1;
        stream_len = 8'd3;
      end else begin
        start = 1'b0;
      end
      if (vld0) begin
        if (vcnt < 16) pat[vcnt] = out0[0];
        vcnt++;
      end
      if (done0) begin
        done_n++;
        if (done_cyc == 0) begin
          done_cyc = c;
          lc_done  = lc0;
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int d1;
    #12;
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_valid", 32'(vld0), 0);
    chk("rst_out", 32'(out0), 0);
    chk("rst_count", 32'(lc0), 0);
    @(negedge clk);
    rst = 1'b0;

    // unipolar, zero weights, ones in
    in0 = 2'b11;
    w0  = '0;
    run0(1'b0, 8'd100, 0);
    chk("t1_done_cycle", done_cyc, 101);
    chk("t1_done_pulses", done_n, 1);
    chk("t1_valid_bits", vcnt, 100);
    chk("t1_count0", 32'(lc_done[0]), 0);
    chk("t1_count1", 32'(lc_done[1]), 0);

    // bipolar, zero weights, zero inputs: every product is 1
    in0 = 2'b00;
    run0(1'b1, 8'd100, 0);
    chk("t2_count0", 32'(lc_done[0]), 100);
    chk("t2_count1", 32'(lc_done[1]), 100);
    chk("t2_valid_bits", vcnt, 100);

    // weights {max,0}: alternating 1,0,... from sel 0
    in0 = 2'b11;
    for (int i = 0; i < 2; i++) begin
      w0[i][0] = 16'hFFFF;
      w0[i][1] = 16'h0000;
    end
    run0(1'b0, 8'd10, 0);
    chk("t4_pattern", 32'(pat), 32'h155);
    chk("t4_count0", 32'(lc_done[0]), 5);
    chk("t4_count1", 32'(lc_done[1]), 5);
    chk("t4_done_cycle", done_cyc, 11);

    // LFSR 1,B400,5A00,..: column 1 sees rotl by 1
    w0[0][0] = 16'h8000;
    w0[0][1] = 16'h8000;
    w0[1][0] = 16'h0100;
    w0[1][1] = 16'h0100;
    run0(1'b0, 8'd10, 0);
    chk("rot_count0", 32'(lc_done[0]), 10);
    chk("rot_count1", 32'(lc_done[1]), 1);

    // start pulsed mid-run must not retrigger or relength
    run0(1'b0, 8'd20, 5);
    chk("t5_done_cycle", done_cyc, 21);
    chk("t5_valid_bits", vcnt, 20);
    chk("t5_done_pulses", done_n, 1);

    run0(1'b0, 8'd0, 0);
    chk("zero_done_cycle", done_cyc, 1);
    chk("zero_valid_bits", vcnt, 0);
    chk("zero_count0", 32'(lc_done[0]), 0);
    chk("zero_count1", 32'(lc_done[1]), 0);

    // asynchronous abort at cycle 5 of a 50-cycle window
    w0  = '0;
    in0 = 2'b00;
    @(negedge clk);
    bipolar    = 1'b1;
    stream_len = 8'd50;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_busy_before", 32'(busy0), 1);
    chk("t6_count_before", 32'(lc0[0]), 4);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", 32'(busy0), 0);
    chk("t6_valid", 32'(vld0), 0);
    chk("t6_out", 32'(out0), 0);
    chk("t6_count", 32'(lc0), 0);
    d1 = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done0) d1++;
    end
    chk("t6_no_done", d1, 0);
    run0(1'b1, 8'd10, 0);
    chk("t6_clean_done", done_cyc, 11);
    chk("t6_clean_count0", 32'(lc_done[0]), 10);
    chk("t6_clean_count1", 32'(lc_done[1]), 10);

    // 8-bit LFSR over one full period: states 1..127 pass
    w1[0][0] = 8'd128;
    in1      = 1'b1;
    d1       = 0;
    @(negedge clk);
    start1 = 1'b1;
    for (int c = 1; c <= 262; c++) begin
      @(posedge clk);
      #1 start1 = 1'b0;
      if (done1 && d1 == 0) begin
        d1 = c;
        chk("t3_count", 32'(lc1[0]), 127);
      end
    end
    chk("t3_done_cycle", d1, 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
